// File: rtl/pipe_arb_pkg.sv
// Shared types and constants for the two-requester adder-pipeline arbiter.
package pipe_arb_pkg;

    localparam int PIPE_LAT = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    function automatic logic [1:0] id_to_onehot(input req_id_t id);
        logic [1:0] oh;
        if (id == 1'b1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/pipe_arbiter_if.sv
// Requester-side handshake bundle: operand requests in, per-requester results out.
interface pipe_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b1;
    logic [1:0]        rsp_valid;
    logic [DATA_W:0]   rsp_data;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/pipe_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers who last transferred.
module pipe_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    logic last_r;

    // Lone requester wins; a tie goes to whoever was not served last
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_r ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end else begin
            grant = 2'b00;
        end
    end

    // Every grant is a transfer, so the pointer simply follows the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (grant != 2'b00) begin
            last_r <= grant[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/pipe_arbiter.sv
// Shares one registered adder pipeline between two requesters and sequences drain/flush.
// Optional grant statistics counters are built when PIPE_ARB_STATS_EN is defined.
module pipe_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LAT    = PIPE_LAT
`ifdef PIPE_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    pipe_arbiter_if.slave     bus,
    input  logic              drain_req,
    input  logic              flush_req,
    output logic              drain_done,
    output logic              busy,
    output logic [DATA_W-1:0] pipe_a,
    output logic [DATA_W-1:0] pipe_b,
    output logic              pipe_flush,
    input  logic [DATA_W:0]   pipe_result
`ifdef PIPE_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    arb_state_t         state_r;
    arb_state_t         state_nxt_s;
    logic               arb_en_s;
    logic [1:0]         grant_s;
    logic               busy_s;
    logic               drain_done_s;
    tag_t               entry0_s;
    tag_t [LAT-1:0]     shadow_r;

    assign arb_en_s = (!rst) && (state_r == RUN);

    pipe_rr_arb u_rr (
        .clk    (clk),
        .rst    (rst),
        .valid  (bus.req_valid),
        .enable (arb_en_s),
        .grant  (grant_s)
    );

    assign bus.req_ready = grant_s;

    // Steer the granted operand pair onto the shared pipeline
    always_comb begin
        pipe_a = {DATA_W{1'b0}};
        pipe_b = {DATA_W{1'b0}};
        case (grant_s)
            2'b01: begin
                pipe_a = bus.req_a0;
                pipe_b = bus.req_b0;
            end
            2'b10: begin
                pipe_a = bus.req_a1;
                pipe_b = bus.req_b1;
            end
            default: begin
                pipe_a = {DATA_W{1'b0}};
                pipe_b = {DATA_W{1'b0}};
            end
        endcase
    end

    // New tag for whatever enters the pipeline this cycle
    always_comb begin
        entry0_s       = '0;
        entry0_s.valid = |grant_s;
        entry0_s.id    = grant_s[1];
    end

    // Shadow mirrors the adder stages; a flush or reset drops every in-flight tag
    always_ff @(posedge clk) begin
        if (rst || (state_r == FLUSH)) begin
            shadow_r <= '0;
        end else begin
            shadow_r <= {shadow_r[LAT-2:0], entry0_s};
        end
    end

    // Occupancy of the shadow
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy_s = busy_s | shadow_r[i].valid;
        end
    end

    assign busy = busy_s;

    // Result is owned by the tag leaving the shadow; suppressed while flushing
    always_comb begin
        bus.rsp_valid = 2'b00;
        if (shadow_r[LAT-1].valid && (state_r != FLUSH) && !rst) begin
            bus.rsp_valid = id_to_onehot(shadow_r[LAT-1].id);
        end else begin
            bus.rsp_valid = 2'b00;
        end
    end

    assign bus.rsp_data = pipe_result;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Flush outranks drain everywhere; drain completes the first cycle the shadow is empty
    always_comb begin
        state_nxt_s  = state_r;
        drain_done_s = 1'b0;
        case (state_r)
            RUN: begin
                if (flush_req) begin
                    state_nxt_s = FLUSH;
                end else if (drain_req) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (flush_req) begin
                    state_nxt_s = FLUSH;
                end else if (!busy_s) begin
                    drain_done_s = 1'b1;
                    state_nxt_s  = RUN;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            FLUSH: begin
                state_nxt_s = RUN;
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    assign drain_done = drain_done_s & ~rst;
    assign pipe_flush = rst | (state_r == FLUSH);

`ifdef PIPE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // Saturating per-requester transfer counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (grant_s[0] && (cnt0_r != {CNT_W{1'b1}})) begin
                cnt0_r <= cnt0_r + 1'b1;
            end else begin
                cnt0_r <= cnt0_r;
            end
            if (grant_s[1] && (cnt1_r != {CNT_W{1'b1}})) begin
                cnt1_r <= cnt1_r + 1'b1;
            end else begin
                cnt1_r <= cnt1_r;
            end
        end
    end

    assign grant_cnt0 = cnt0_r;
    assign grant_cnt1 = cnt1_r;
`endif

endmodule

// File: tb/tb_pipe_arbiter.sv
// Randomised and directed bench for pipe_arbiter against a queue-based reference model.
module tb_pipe_arbiter;

    logic       clk;
    logic       rst;
    logic       drain_req;
    logic       flush_req;
    logic       drain_done;
    logic       busy;
    logic [7:0] pipe_a;
    logic [7:0] pipe_b;
    logic       pipe_flush;
    logic [8:0] pipe_result;
`ifdef PIPE_ARB_STATS_EN
    logic [2:0] grant_cnt0;
    logic [2:0] grant_cnt1;
`endif

    pipe_arbiter_if #(.DATA_W(8)) bus ();

    pipe_arbiter #(
        .DATA_W (8),
        .LAT    (3)
`ifdef PIPE_ARB_STATS_EN
        ,
        .CNT_W  (3)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .drain_req   (drain_req),
        .flush_req   (flush_req),
        .drain_done  (drain_done),
        .busy        (busy),
        .pipe_a      (pipe_a),
        .pipe_b      (pipe_b),
        .pipe_flush  (pipe_flush),
        .pipe_result (pipe_result)
`ifdef PIPE_ARB_STATS_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared 3-stage adder pipeline with asynchronous clear on its flush pin
    logic [7:0] ar, br;
    logic [8:0] sr, rr;
    always @(posedge clk or posedge pipe_flush) begin
        if (pipe_flush) begin
            ar <= 8'h00; br <= 8'h00; sr <= 9'h000; rr <= 9'h000;
        end else begin
            ar <= pipe_a; br <= pipe_b;
            sr <= {1'b0, ar} + {1'b0, br};
            rr <= sr;
        end
    end
    assign pipe_result = rr;

    // Reference model: in-flight operations as a queue of {transfer cycle, owner, sum}
    typedef struct { int t; int id; int sum; } op_t;
    op_t q[$];
    int  mst;     // 0 RUN, 1 DRAIN, 2 FLUSH
    int  mlast;
    int  mcyc;
    int  mcnt0, mcnt1;
    int  n_vec, n_err;
    bit  sim_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, mcyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic [1:0] e_ready, e_rsp;
        logic [7:0] e_a, e_b;
        logic       e_dd, e_busy, e_pf, due;
        op_t        op;
        e_ready = 2'b00;
        if (!rst && mst == 0) begin
            if (bus.req_valid == 2'b11) e_ready = (mlast == 1) ? 2'b01 : 2'b10;
            else                        e_ready = bus.req_valid;
        end
        e_a = e_ready[0] ? bus.req_a0 : (e_ready[1] ? bus.req_a1 : 8'h00);
        e_b = e_ready[0] ? bus.req_b0 : (e_ready[1] ? bus.req_b1 : 8'h00);
        e_busy = (q.size() != 0);
        due    = (q.size() != 0) && (q[0].t == mcyc - 3);
        e_rsp  = 2'b00;
        if (due && !rst && mst != 2) e_rsp = (q[0].id == 1) ? 2'b10 : 2'b01;
        e_dd = !rst && (mst == 1) && !e_busy && !flush_req;
        e_pf = rst || (mst == 2);

        check("req_ready",  32'(bus.req_ready), 32'(e_ready));
        check("pipe_a",     32'(pipe_a),        32'(e_a));
        check("pipe_b",     32'(pipe_b),        32'(e_b));
        check("rsp_valid",  32'(bus.rsp_valid), 32'(e_rsp));
        if (e_rsp != 2'b00) check("rsp_data", 32'(bus.rsp_data), 32'(q[0].sum));
        check("drain_done", 32'(drain_done),    32'(e_dd));
        check("busy",       32'(busy),          32'(e_busy));
        check("pipe_flush", 32'(pipe_flush),    32'(e_pf));
`ifdef PIPE_ARB_STATS_EN
        check("grant_cnt0", 32'(grant_cnt0), 32'(mcnt0));
        check("grant_cnt1", 32'(grant_cnt1), 32'(mcnt1));
`endif

        if (rst) begin
            q.delete();
            mst = 0; mlast = 1; mcnt0 = 0; mcnt1 = 0;
        end else begin
            if (due) void'(q.pop_front());
            if (mst == 2) q.delete();
            if (e_ready != 2'b00) begin
                op.t   = mcyc;
                op.id  = e_ready[1] ? 1 : 0;
                op.sum = int'(e_a) + int'(e_b);
                q.push_back(op);
                mlast = op.id;
                if (op.id == 0 && mcnt0 < 7) mcnt0++;
                if (op.id == 1 && mcnt1 < 7) mcnt1++;
            end
            case (mst)
                0:       mst = flush_req ? 2 : (drain_req ? 1 : 0);
                1:       mst = flush_req ? 2 : (!e_busy ? 0 : 1);
                default: mst = 0;
            endcase
        end
        mcyc++;
    endtask

    // Compare process: one model step per cycle, sampled on the falling edge
    initial begin
        mst = 0; mlast = 1; mcyc = 0; mcnt0 = 0; mcnt1 = 0;
        @(posedge clk);
        while (!sim_done) begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 2'b00;
        bus.req_a0 = 8'h00; bus.req_b0 = 8'h00;
        bus.req_a1 = 8'h00; bus.req_b1 = 8'h00;
        drain_req = 1'b0; flush_req = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; sim_done = 1'b0;
        rst = 1'b1;
        idle();
        bus.req_valid = 2'b11;
        repeat (2) nc();
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_pflush", 32'(pipe_flush), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        nc();
        rst = 1'b0;
        idle();
        repeat (2) nc();

        // Contention right after reset: requester 0 wins the first tie
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 2'b11;
            bus.req_a0 = 8'(k); bus.req_b0 = 8'h10;
            bus.req_a1 = 8'(k); bus.req_b1 = 8'h20;
            @(negedge clk);
            check("tie_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            nc();
        end
        idle();
        repeat (4) nc();

        // Single op and carry case
        bus.req_valid = 2'b01; bus.req_a0 = 8'h12; bus.req_b0 = 8'h34;
        nc(); idle(); nc(); nc();
        @(negedge clk);
        check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_rsp_data", 32'(bus.rsp_data), 32'h046);
        nc();
        bus.req_valid = 2'b10; bus.req_a1 = 8'hFF; bus.req_b1 = 8'hFF;
        nc(); idle(); nc(); nc();
        @(negedge clk);
        check("carry_rsp_valid", 32'(bus.rsp_valid), 32'd2);
        check("carry_rsp_data", 32'(bus.rsp_data), 32'h1FE);
        nc();

        // Back-to-back stream from requester 1
        for (int k = 0; k < 10; k++) begin
            bus.req_valid = 2'b10;
            bus.req_a1 = 8'($urandom_range(0, 255));
            bus.req_b1 = 8'($urandom_range(0, 255));
            if (k >= 1) begin
                @(negedge clk);
                check("b2b_busy", 32'(busy), 32'd1);
            end
            nc();
        end
        idle();
        repeat (4) nc();

        // Drain with three ops in flight
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 2'b01; bus.req_a0 = 8'(k + 1); bus.req_b0 = 8'(k + 2);
            if (k == 2) drain_req = 1'b1;
            nc();
        end
        idle();
        bus.req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("drain_ready", 32'(bus.req_ready), 32'd0);
            check("drain_rsp", 32'(bus.rsp_valid), 32'd1);
            check("drain_done_early", 32'(drain_done), 32'd0);
            nc();
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("drain_done_pulse", 32'(drain_done), 32'd1);
        nc();
        @(negedge clk);
        check("drain_done_clear", 32'(drain_done), 32'd0);
        nc();

        // Flush, alone and then together with drain
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 3; k++) begin
                bus.req_valid = 2'b01; bus.req_a0 = 8'(k + 7); bus.req_b0 = 8'h01;
                if (k == 2) begin
                    flush_req = 1'b1;
                    drain_req = (rep == 1);
                end
                nc();
            end
            idle();
            @(negedge clk);
            check("flush_pipe_flush", 32'(pipe_flush), 32'd1);
            check("flush_rsp0", 32'(bus.rsp_valid), 32'd0);
            check("flush_dd", 32'(drain_done), 32'd0);
            nc();
            bus.req_valid = 2'b01; bus.req_a0 = 8'h05; bus.req_b0 = 8'h06;
            @(negedge clk);
            check("flush_regrant", 32'(bus.req_ready), 32'd1);
            check("flush_rsp1", 32'(bus.rsp_valid), 32'd0);
            check("flush_dd1", 32'(drain_done), 32'd0);
            nc();
            idle();
            @(negedge clk);
            check("flush_rsp2", 32'(bus.rsp_valid), 32'd0);
            repeat (4) nc();
        end

        // Randomised traffic with occasional drain, flush and reset
        for (int k = 0; k < 1500; k++) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.req_a0 = 8'($urandom_range(0, 255)); bus.req_b0 = 8'($urandom_range(0, 255));
            bus.req_a1 = 8'($urandom_range(0, 255)); bus.req_b1 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
            flush_req = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 199) == 0);
            nc();
        end
        rst = 1'b0;
        idle();
        repeat (5) nc();

`ifdef PIPE_ARB_STATS_EN
        // Counters: count, clear on reset with ops in flight, then saturate
        rst = 1'b1; nc(); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = 2'b01; bus.req_a0 = 8'(k); bus.req_b0 = 8'h01;
            nc();
        end
        idle();
        @(negedge clk);
        check("cnt0_five", 32'(grant_cnt0), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        nc();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("cnt0_cleared", 32'(grant_cnt0), 32'd0);
            check("rst_no_rsp_after", 32'(bus.rsp_valid), 32'd0);
            nc();
        end
        for (int k = 0; k < 9; k++) begin
            bus.req_valid = 2'b01;
            nc();
        end
        idle();
        @(negedge clk);
        check("cnt0_saturate", 32'(grant_cnt0), 32'd7);
        repeat (4) nc();
`endif

        sim_done = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
